// File: rtl/digit_serial_add_sub.sv
// ============================================================================
// Module : digit_serial_add_sub
// Brief  : LSB-first digit-serial adder/subtractor with word framing and flags
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module digit_serial_add_sub #(
  parameter int DIGIT_W     = 4,
  parameter int WORD_DIGITS = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] out_sum,
  output logic               out_last,
  output logic               out_carry,
  output logic               out_overflow,
  output logic               out_err
);

  localparam int               CNT_W    = $clog2(WORD_DIGITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_DIGITS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic               valid_q, valid_d;
  logic [DIGIT_W-1:0] sum_q, sum_d;
  logic               last_q, last_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic               w_mode;
  logic               w_cin;
  logic [DIGIT_W-1:0] w_bx;
  logic [DIGIT_W:0]   w_full;
  logic [DIGIT_W-1:0] w_sum;
  logic               w_cout;
  logic               w_cin_msb;
  logic               w_accept;
  logic               w_is_last;
  logic               w_frame_err;

  // A first digit always starts a fresh word, so its mode/carry-in come from sub.
  assign w_mode    = in_first ? sub : mode_q;
  assign w_cin     = in_first ? sub : carry_q;
  assign w_bx      = b ^ {DIGIT_W{w_mode}};
  assign w_full    = {1'b0, a} + {1'b0, w_bx} + {{DIGIT_W{1'b0}}, w_cin};
  assign w_sum     = w_full[DIGIT_W-1:0];
  assign w_cout    = w_full[DIGIT_W];
  // Carry into the MSB recovered from the MSB sum bit and its two addend bits.
  assign w_cin_msb = w_sum[DIGIT_W-1] ^ a[DIGIT_W-1] ^ w_bx[DIGIT_W-1];

  assign w_accept    = in_valid & (in_first | (state_q == ST_RUN));
  assign w_is_last   = ~in_first & (count_q == LAST_IDX);
  assign w_frame_err = in_valid & (in_first ? (state_q == ST_RUN) : (state_q == ST_IDLE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    if (w_accept) begin
      carry_d = w_cout;
      if (in_first) begin
        state_d = ST_RUN;
        count_d = CNT_W'(1);
        mode_d  = sub;
      end else if (w_is_last) begin
        state_d = ST_IDLE;
        count_d = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    valid_d = w_accept;
    sum_d   = w_accept ? w_sum : sum_q;
    last_d  = w_accept & w_is_last;
    cout_d  = w_accept & w_is_last & w_cout;
    ovf_d   = w_accept & w_is_last & (w_cout ^ w_cin_msb);
    err_d   = w_frame_err;
  end

  assign out_valid    = valid_q;
  assign out_sum      = sum_q;
  assign out_last     = last_q;
  assign out_carry    = cout_q;
  assign out_overflow = ovf_q;
  assign out_err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_digit_serial_add_sub.sv
// ============================================================================
// Module : tb_digit_serial_add_sub
// Brief  : Directed checks of digit_serial_add_sub plus a wide-word model run
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_digit_serial_add_sub;

  logic       clk;
  logic       reset_n;
  logic       in_valid, in_first, sub;
  logic [3:0] a, b;
  logic       out_valid, out_last, out_carry, out_overflow, out_err;
  logic [3:0] out_sum;

  logic       in_valid3, in_first3, sub3;
  logic [2:0] a3, b3;
  logic       out_valid3, out_last3, out_carry3, out_overflow3, out_err3;
  logic [2:0] out_sum3;

  int n_vec = 0;
  int n_err = 0;

  // {valid, sum, last, carry, overflow, err}
  wire [8:0] obs  = {out_valid, out_sum, out_last, out_carry, out_overflow, out_err};
  wire [7:0] obs3 = {out_valid3, out_sum3, out_last3, out_carry3, out_overflow3, out_err3};

  digit_serial_add_sub #(.DIGIT_W(4), .WORD_DIGITS(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_first(in_first),
    .sub(sub), .a(a), .b(b), .out_valid(out_valid), .out_sum(out_sum),
    .out_last(out_last), .out_carry(out_carry), .out_overflow(out_overflow),
    .out_err(out_err)
  );

  digit_serial_add_sub #(.DIGIT_W(3), .WORD_DIGITS(5)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid3), .in_first(in_first3),
    .sub(sub3), .a(a3), .b(b3), .out_valid(out_valid3), .out_sum(out_sum3),
    .out_last(out_last3), .out_carry(out_carry3), .out_overflow(out_overflow3),
    .out_err(out_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic v, input logic f, input logic s,
                      input logic [3:0] da, input logic [3:0] db);
    in_valid = v; in_first = f; sub = s; a = da; b = db;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (obs !== 9'b0_0000_0000) begin
      n_err++; $display("FAIL reset_state got %b exp %b", obs, 9'b0_0000_0000);
    end
    n_vec++;
    if (obs3 !== 8'b0) begin
      n_err++; $display("FAIL reset_state_w3 got %b exp %b", obs3, 8'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_add();
    step(1, 1, 0, 4'hF, 4'h1);
    n_vec++;
    if (obs !== 9'b1_0000_0000) begin
      n_err++; $display("FAIL add_d0 got %b exp %b", obs, 9'b1_0000_0000);
    end
    step(1, 0, 0, 4'h7, 4'h0);
    n_vec++;
    if (obs !== 9'b1_1000_1010) begin
      n_err++; $display("FAIL add_d1 got %b exp %b", obs, 9'b1_1000_1010);
    end
    step(0, 0, 0, 4'h0, 4'h0);
    n_vec++;
    if (obs !== 9'b0_1000_0000) begin
      n_err++; $display("FAIL add_idle_hold got %b exp %b", obs, 9'b0_1000_0000);
    end
  endtask

  task automatic test_sub();
    // 0x05 - 0x07 = 0xFE with borrow; sub deasserted on digit 1 must not matter
    step(1, 1, 1, 4'h5, 4'h7);
    n_vec++;
    if (obs !== 9'b1_1110_0000) begin
      n_err++; $display("FAIL sub_borrow_d0 got %b exp %b", obs, 9'b1_1110_0000);
    end
    step(1, 0, 0, 4'h0, 4'h0);
    n_vec++;
    if (obs !== 9'b1_1111_1000) begin
      n_err++; $display("FAIL sub_borrow_d1 got %b exp %b", obs, 9'b1_1111_1000);
    end
    // 0x80 - 0x01 = 0x7F, no borrow, signed overflow
    step(1, 1, 1, 4'h0, 4'h1);
    n_vec++;
    if (obs !== 9'b1_1111_0000) begin
      n_err++; $display("FAIL sub_ovf_d0 got %b exp %b", obs, 9'b1_1111_0000);
    end
    step(1, 0, 1, 4'h8, 4'h0);
    n_vec++;
    if (obs !== 9'b1_0111_1110) begin
      n_err++; $display("FAIL sub_ovf_d1 got %b exp %b", obs, 9'b1_0111_1110);
    end
  endtask

  task automatic test_stall();
    step(1, 1, 0, 4'hF, 4'h1);
    n_vec++;
    if (obs !== 9'b1_0000_0000) begin
      n_err++; $display("FAIL stall_d0 got %b exp %b", obs, 9'b1_0000_0000);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 4'hA, 4'h5);
      n_vec++;
      if (obs !== 9'b0_0000_0000) begin
        n_err++; $display("FAIL stall_gap%0d got %b exp %b", i, obs, 9'b0_0000_0000);
      end
    end
    step(1, 0, 0, 4'h7, 4'h0);
    n_vec++;
    if (obs !== 9'b1_1000_1010) begin
      n_err++; $display("FAIL stall_d1 got %b exp %b", obs, 9'b1_1000_1010);
    end
  endtask

  task automatic test_back_to_back();
    // 0x12 + 0x34 = 0x46, then immediately 0x10 - 0x20 = 0xF0 (borrow)
    step(1, 1, 0, 4'h2, 4'h4);
    n_vec++;
    if (obs !== 9'b1_0110_0000) begin
      n_err++; $display("FAIL b2b_w0d0 got %b exp %b", obs, 9'b1_0110_0000);
    end
    step(1, 0, 0, 4'h1, 4'h3);
    n_vec++;
    if (obs !== 9'b1_0100_1000) begin
      n_err++; $display("FAIL b2b_w0d1 got %b exp %b", obs, 9'b1_0100_1000);
    end
    step(1, 1, 1, 4'h0, 4'h0);
    n_vec++;
    if (obs !== 9'b1_0000_0000) begin
      n_err++; $display("FAIL b2b_w1d0 got %b exp %b", obs, 9'b1_0000_0000);
    end
    step(1, 0, 0, 4'h1, 4'h2);
    n_vec++;
    if (obs !== 9'b1_1111_1000) begin
      n_err++; $display("FAIL b2b_w1d1 got %b exp %b", obs, 9'b1_1111_1000);
    end
  endtask

  task automatic test_framing();
    step(1, 0, 0, 4'h3, 4'h3);
    n_vec++;
    if (obs !== 9'b0_1111_0001) begin
      n_err++; $display("FAIL frame_orphan got %b exp %b", obs, 9'b0_1111_0001);
    end
    step(0, 0, 0, 4'h0, 4'h0);
    n_vec++;
    if (obs !== 9'b0_1111_0000) begin
      n_err++; $display("FAIL frame_err_pulse got %b exp %b", obs, 9'b0_1111_0000);
    end
    step(1, 1, 1, 4'h3, 4'h4);
    n_vec++;
    if (obs !== 9'b1_1111_0000) begin
      n_err++; $display("FAIL frame_abandon_d0 got %b exp %b", obs, 9'b1_1111_0000);
    end
    // restart as an add: carry and mode from the abandoned sub word must not leak
    step(1, 1, 0, 4'hF, 4'h1);
    n_vec++;
    if (obs !== 9'b1_0000_0001) begin
      n_err++; $display("FAIL frame_restart got %b exp %b", obs, 9'b1_0000_0001);
    end
    step(1, 0, 0, 4'h7, 4'h0);
    n_vec++;
    if (obs !== 9'b1_1000_1010) begin
      n_err++; $display("FAIL frame_restart_last got %b exp %b", obs, 9'b1_1000_1010);
    end
  endtask

  task automatic test_async_reset();
    step(1, 1, 0, 4'h9, 4'h3);
    n_vec++;
    if (obs !== 9'b1_1100_0000) begin
      n_err++; $display("FAIL arst_pre got %b exp %b", obs, 9'b1_1100_0000);
    end
    #1 reset_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== 9'b0_0000_0000) begin
      n_err++; $display("FAIL arst_immediate got %b exp %b", obs, 9'b0_0000_0000);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    // the interrupted word must not continue: a non-first digit is an error
    step(1, 0, 0, 4'h1, 4'h1);
    n_vec++;
    if (obs !== 9'b0_0000_0001) begin
      n_err++; $display("FAIL arst_discard got %b exp %b", obs, 9'b0_0000_0001);
    end
    step(1, 1, 0, 4'hF, 4'h1);
    n_vec++;
    if (obs !== 9'b1_0000_0000) begin
      n_err++; $display("FAIL arst_fresh_d0 got %b exp %b", obs, 9'b1_0000_0000);
    end
    step(1, 0, 0, 4'hF, 4'h0);
    n_vec++;
    if (obs !== 9'b1_0000_1100) begin
      n_err++; $display("FAIL arst_fresh_d1 got %b exp %b", obs, 9'b1_0000_1100);
    end
    step(0, 0, 0, 4'h0, 4'h0);
  endtask

  // 3-bit digits, 5-digit (15-bit) words, back-to-back, against a full-width model
  task automatic test_random();
    logic [14:0] wa, wb, wbx;
    logic [15:0] r;
    logic        s, ovf, last;
    logic [7:0]  exp3;
    for (int w = 0; w < 300; w++) begin
      wa  = 15'($urandom);
      wb  = 15'($urandom);
      s   = 1'($urandom_range(0, 1));
      wbx = s ? ~wb : wb;
      r   = {1'b0, wa} + {1'b0, wbx} + {15'd0, s};
      ovf = (wa[14] == wbx[14]) && (r[14] != wa[14]);
      for (int d = 0; d < 5; d++) begin
        in_valid3 = 1'b1;
        in_first3 = (d == 0);
        sub3      = (d == 0) ? s : 1'($urandom_range(0, 1));
        a3        = wa[3*d +: 3];
        b3        = wb[3*d +: 3];
        @(posedge clk); #1;
        last = (d == 4);
        exp3 = {1'b1, r[3*d +: 3], last, last & r[15], last & ovf, 1'b0};
        n_vec++;
        if (obs3 !== exp3) begin
          n_err++;
          $display("FAIL rand_w%0d_d%0d a=%h b=%h sub=%b got %b exp %b",
                   w, d, wa, wb, s, obs3, exp3);
        end
      end
    end
    in_valid3 = 1'b0;
    in_first3 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0; in_first  = 1'b0; sub  = 1'b0; a  = '0; b  = '0;
    in_valid3 = 1'b0; in_first3 = 1'b0; sub3 = 1'b0; a3 = '0; b3 = '0;
    test_reset();
    test_add();
    test_sub();
    test_stall();
    test_back_to_back();
    test_framing();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
